pwm_carrier_sched: RTL and testbench

PWM_CARRIER_SCHED -- requirements
Module: pwm_carrier_sched

---
 rtl/pwm_carrier_sched.sv | 194 +++++++++++++++++++
 tb/tb_pwm_carrier_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_sched.sv
// pwm_carrier_sched
//   Up/down (triangle) carrier generator with double-buffered period and
//   compare registers for a two-channel PWM comparator stage.
//
//   The host writes period/compare values into shadow registers through a
//   load_req/load_ack handshake. The shadow values become active only at a
//   carrier valley or when the carrier starts from idle, so an update can
//   never tear a carrier period in half.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ce         clock enable; the carrier and FSM advance only when ce=1
//   enable     run request; when it drops, the carrier stops at the next valley
//   period_in  requested carrier peak value P
//   cmp1_in    requested compare value, channel 1
//   cmp2_in    requested compare value, channel 2
//   load_req   host request to capture period_in/cmp1_in/cmp2_in
//   load_ack   one-clk capture acknowledge
//   carrier    triangle carrier
//   compare_1  active compare value, channel 1 (clamped to P)
//   compare_2  active compare value, channel 2 (clamped to P)
//   valley_evt one-clk strobe for a valley/start step
//   peak_evt   one-clk strobe for a peak step
//   running    FSM is not idle
//   pending    shadow values wait to be applied
//
//   All outputs are registers. An event strobe, an application of the shadow
//   values and the matching carrier step all become visible together on the
//   clk after the ce=1 cycle that processed them.
module pwm_carrier_sched #(
  parameter int PWMWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                enable,
  input  logic [PWMWIDTH-1:0] period_in,
  input  logic [PWMWIDTH-1:0] cmp1_in,
  input  logic [PWMWIDTH-1:0] cmp2_in,
  input  logic                load_req,
  output logic                load_ack,
  output logic [PWMWIDTH-1:0] carrier,
  output logic [PWMWIDTH-1:0] compare_1,
  output logic [PWMWIDTH-1:0] compare_2,
  output logic                valley_evt,
  output logic                peak_evt,
  output logic                running,
  output logic                pending
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t state_q, state_d;

  logic [PWMWIDTH-1:0] carrier_q, carrier_d;
  logic [PWMWIDTH-1:0] period_q, period_d;
  logic [PWMWIDTH-1:0] cmp1_q, cmp1_d;
  logic [PWMWIDTH-1:0] cmp2_q, cmp2_d;
  logic [PWMWIDTH-1:0] sh_period_q, sh_period_d;
  logic [PWMWIDTH-1:0] sh_cmp1_q, sh_cmp1_d;
  logic [PWMWIDTH-1:0] sh_cmp2_q, sh_cmp2_d;
  logic                pending_q, pending_d;
  logic                load_ack_q, load_ack_d;
  logic                valley_q, valley_d;
  logic                peak_q, peak_d;

  logic                capture;
  logic                apply;
  logic [PWMWIDTH-1:0] eff_period;

  always_comb begin
    state_d     = state_q;
    carrier_d   = carrier_q;
    period_d    = period_q;
    cmp1_d      = cmp1_q;
    cmp2_d      = cmp2_q;
    sh_period_d = sh_period_q;
    sh_cmp1_d   = sh_cmp1_q;
    sh_cmp2_d   = sh_cmp2_q;
    pending_d   = pending_q;
    valley_d    = 1'b0;
    peak_d      = 1'b0;
    apply       = 1'b0;

    // Held load_req alternates capture/ack, so the ack flop gates the capture.
    capture    = load_req && !load_ack_q;
    load_ack_d = capture;

    // Period that will be in force after an application point this cycle;
    // apply is only ever raised when pending_q is set.
    eff_period = pending_q ? sh_period_q : period_q;

    if (ce) begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            apply = pending_q;
            if (eff_period != '0) begin
              state_d   = UP;
              carrier_d = PWMWIDTH'(1);
              valley_d  = 1'b1;
            end
          end
        end
        UP: begin
          // carrier never exceeds P, so the increment cannot wrap even
          // when P is all ones.
          if (carrier_q < period_q) begin
            carrier_d = carrier_q + PWMWIDTH'(1);
          end else begin
            peak_d    = 1'b1;
            carrier_d = carrier_q - PWMWIDTH'(1);
            state_d   = DOWN;
          end
        end
        DOWN: begin
          if (carrier_q != '0) begin
            carrier_d = carrier_q - PWMWIDTH'(1);
          end else begin
            valley_d = 1'b1;
            apply    = pending_q;
            if (enable && (eff_period != '0)) begin
              state_d   = UP;
              carrier_d = PWMWIDTH'(1);
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          carrier_d = '0;
        end
      endcase
    end

    // Application reads the shadow registers before this cycle's capture
    // overwrites them, so a simultaneous capture waits for the next point.
    if (apply) begin
      period_d  = sh_period_q;
      cmp1_d    = (sh_cmp1_q > sh_period_q) ? sh_period_q : sh_cmp1_q;
      cmp2_d    = (sh_cmp2_q > sh_period_q) ? sh_period_q : sh_cmp2_q;
      pending_d = 1'b0;
    end

    if (capture) begin
      sh_period_d = period_in;
      sh_cmp1_d   = cmp1_in;
      sh_cmp2_d   = cmp2_in;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      carrier_q   <= '0;
      period_q    <= '0;
      cmp1_q      <= '0;
      cmp2_q      <= '0;
      sh_period_q <= '0;
      sh_cmp1_q   <= '0;
      sh_cmp2_q   <= '0;
      pending_q   <= 1'b0;
      load_ack_q  <= 1'b0;
      valley_q    <= 1'b0;
      peak_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      carrier_q   <= carrier_d;
      period_q    <= period_d;
      cmp1_q      <= cmp1_d;
      cmp2_q      <= cmp2_d;
      sh_period_q <= sh_period_d;
      sh_cmp1_q   <= sh_cmp1_d;
      sh_cmp2_q   <= sh_cmp2_d;
      pending_q   <= pending_d;
      load_ack_q  <= load_ack_d;
      valley_q    <= valley_d;
      peak_q      <= peak_d;
    end
  end

  assign carrier    = carrier_q;
  assign compare_1  = cmp1_q;
  assign compare_2  = cmp2_q;
  assign load_ack   = load_ack_q;
  assign valley_evt = valley_q;
  assign peak_evt   = peak_q;
  assign pending    = pending_q;
  assign running    = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_carrier_sched.sv
// Testbench for pwm_carrier_sched. A narrow carrier width keeps the
// all-ones period short enough to run in full. The reference model tracks
// the position inside a 2P-step carrier period and derives the triangle
// from it.
module tb_pwm_carrier_sched;

  localparam int W    = 6;
  localparam int PMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, ce, enable, load_req;
  logic [W-1:0] period_in, cmp1_in, cmp2_in;
  logic         load_ack, valley_evt, peak_evt, running, pending;
  logic [W-1:0] carrier, compare_1, compare_2;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_run, m_pend, m_ack, m_valley, m_peak;
  int m_pos, m_p, m_c1, m_c2, m_sp, m_sc1, m_sc2;

  always #5 clk = ~clk;

  pwm_carrier_sched #(.PWMWIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .enable     (enable),
    .period_in  (period_in),
    .cmp1_in    (cmp1_in),
    .cmp2_in    (cmp2_in),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .carrier    (carrier),
    .compare_1  (compare_1),
    .compare_2  (compare_2),
    .valley_evt (valley_evt),
    .peak_evt   (peak_evt),
    .running    (running),
    .pending    (pending)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_apply();
    if (m_pend) begin
      m_p    = m_sp;
      m_c1   = min2(m_sc1, m_sp);
      m_c2   = min2(m_sc2, m_sp);
      m_pend = 0;
    end
  endtask

  task automatic model_step();
    bit cap;
    if (rst) begin
      m_run = 0; m_pend = 0; m_ack = 0; m_valley = 0; m_peak = 0;
      m_pos = 0; m_p = 0; m_c1 = 0; m_c2 = 0; m_sp = 0; m_sc1 = 0; m_sc2 = 0;
      return;
    end
    cap      = load_req && !m_ack;
    m_valley = 0;
    m_peak   = 0;
    if (ce) begin
      if (!m_run) begin
        if (enable) begin
          model_apply();
          if (m_p != 0) begin
            m_run = 1; m_pos = 1; m_valley = 1;
          end
        end
      end else if (m_pos == 0) begin
        m_valley = 1;
        model_apply();
        if (enable && m_p != 0) m_pos = 1;
        else m_run = 0;
      end else begin
        if (m_pos == m_p) m_peak = 1;
        m_pos = (m_pos + 1) % (2 * m_p);
      end
    end
    if (cap) begin
      m_sp = period_in; m_sc1 = cmp1_in; m_sc2 = cmp2_in;
      m_pend = 1;
    end
    m_ack = cap;
  endtask

  function automatic int model_carrier();
    if (!m_run) return 0;
    return (m_pos <= m_p) ? m_pos : (2 * m_p - m_pos);
  endfunction

  // One clk: drive inputs, advance the model at the edge, check #1 later.
  task automatic cyc(input bit r, input bit c, input bit en, input bit lr,
                     input int p, input int c1, input int c2);
    rst = r; ce = c; enable = en; load_req = lr;
    period_in = W'(p); cmp1_in = W'(c1); cmp2_in = W'(c2);
    @(posedge clk);
    model_step();
    #1;
    chk("carrier",   carrier,    model_carrier());
    chk("compare_1", compare_1,  m_c1);
    chk("compare_2", compare_2,  m_c2);
    chk("valley",    valley_evt, m_valley);
    chk("peak",      peak_evt,   m_peak);
    chk("running",   running,    m_run);
    chk("pending",   pending,    m_pend);
    chk("load_ack",  load_ack,   m_ack);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(0, 1, en, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; ce = 0; enable = 0; load_req = 0;
    period_in = '0; cmp1_in = '0; cmp2_in = '0;

    // reset with other inputs active: reset wins
    cyc(1, 1, 1, 1, 5, 5, 5);
    cyc(1, 1, 1, 1, 5, 5, 5);

    // P=4, cmp 2/3, then run
    cyc(0, 0, 0, 1, 4, 2, 3);
    cyc(0, 0, 0, 0, 0, 0, 0);
    run(20, 1);

    // cmp1=1 loaded while rising, applied at next valley
    cyc(0, 1, 1, 1, 4, 1, 3);
    run(12, 1);

    // cmp1=9 clamps to 4
    cyc(0, 1, 1, 1, 4, 9, 3);
    run(12, 1);

    // load_req held high: ack every other clk, latest wins
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, 3 + i, i, 2 * i);
    run(14, 1);

    // stop request: finish down-slope then idle
    run(3, 1);
    run(14, 0);

    // P=0 during a run, re-enable stays idle, then P=1
    cyc(0, 1, 1, 1, 4, 2, 3);
    run(12, 1);
    cyc(0, 1, 1, 1, 0, 1, 1);
    run(14, 1);
    cyc(0, 1, 1, 1, 1, 0, 5);
    run(10, 1);

    // all-ones period: full peak without wrap
    cyc(0, 1, 1, 1, PMAX, PMAX, 7);
    run(2 * PMAX + 6, 1);

    // ce toggling, then reset mid-period
    cyc(0, 1, 1, 1, 4, 2, 3);
    run(14, 1);
    for (int i = 0; i < 10; i++) cyc(0, i % 2 == 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 7, 7, 7);
    cyc(0, 1, 1, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int p;
      p = ($urandom_range(0, 9) == 0) ? $urandom_range(0, PMAX) : $urandom_range(0, 6);
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) != 0,
          $urandom_range(0, 7) == 0,
          p, $urandom_range(0, PMAX), $urandom_range(0, 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
